// File: rtl/flat_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : flat_io_pkg                                                |
// | Purpose : Shared types and helpers for the flat I/O sequencer:       |
// |           sequencer state encoding and chunk-count arithmetic.       |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package flat_io_pkg;

   // Sequencer phases; LOAD is the reset state.
   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2
   } flat_io_state_t;

   // Integer ceiling division, used to size the chunked registers.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flat_io_sequencer_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : flat_chunk_shifter                                         |
// | Purpose : MSB-first chunk shift register with parallel load and a    |
// |           chunk counter that wraps after the final chunk.            |
// | Ports   : clk, rst_n          clock / async active-low reset         |
// |           load_i, load_data_i parallel load (clears the count)       |
// |           shift_i, shift_data_i shift one chunk in at the bottom     |
// |           clr_i               clear the chunk count                  |
// |           shifted_o           register value after a shift          |
// |           top_chunk_o         most significant chunk                 |
// |           last_o              count points at the final chunk        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module flat_chunk_shifter
   import flat_io_pkg::*;
#(
   parameter int CHUNK_W  = 8,
   parameter int N_CHUNKS = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_i,
   input  logic [N_CHUNKS*CHUNK_W-1:0]   load_data_i,
   input  logic                          shift_i,
   input  logic [CHUNK_W-1:0]            shift_data_i,
   input  logic                          clr_i,
   output logic [N_CHUNKS*CHUNK_W-1:0]   shifted_o,
   output logic [CHUNK_W-1:0]            top_chunk_o,
   output logic                          last_o
);

   localparam int W     = N_CHUNKS * CHUNK_W;
   localparam int CNT_W = cnt_width(N_CHUNKS);

   logic [W-1:0]         data_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [W+CHUNK_W-1:0] w_cat;

   // Appending the new chunk and keeping the low W bits is a left shift
   // that also works when the register is a single chunk wide.
   assign w_cat       = {data_q, shift_data_i};
   assign shifted_o   = w_cat[W-1:0];
   assign top_chunk_o = data_q[W-1 -: CHUNK_W];
   assign last_o      = (cnt_q == CNT_W'(N_CHUNKS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i || clr_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (load_i) begin
            data_q <= load_data_i;
         end else if (shift_i) begin
            data_q <= shifted_o;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/flat_io_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : flat_io_sequencer                                          |
// | Purpose : Assembles a wide flattened DUT input from a chunk stream,  |
// |           waits a programmable settle time, captures the flattened   |
// |           DUT output and streams it back out MSB chunk first.        |
// | Ports   : clk, rst_n                  clock / async active-low reset |
// |           s_valid/s_ready/s_data/s_last  input chunk stream          |
// |           m_valid/m_ready/m_data/m_last  output chunk stream         |
// |           dut_in   registered flattened DUT input                    |
// |           dut_out  flattened DUT output                              |
// |           err      sticky framing error                              |
// |           frame_cnt completed frames (wraps)                         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module flat_io_sequencer
   import flat_io_pkg::*;
#(
   parameter int IN_W    = 27,
   parameter int OUT_W   = 8,
   parameter int CHUNK_W = 8,
   parameter int DUT_LAT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [CHUNK_W-1:0] s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [CHUNK_W-1:0] m_data,
   output logic               m_last,
   output logic [IN_W-1:0]    dut_in,
   input  logic [OUT_W-1:0]   dut_out,
   output logic               err,
   output logic [15:0]        frame_cnt
);

   localparam int IN_CHUNKS  = ceil_div(IN_W, CHUNK_W);
   localparam int OUT_CHUNKS = ceil_div(OUT_W, CHUNK_W);
   localparam int IN_PAD_W   = IN_CHUNKS * CHUNK_W;
   localparam int OUT_PAD_W  = OUT_CHUNKS * CHUNK_W;
   localparam int SET_W      = cnt_width(DUT_LAT + 1);

   flat_io_state_t      state_q, state_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [IN_W-1:0]     dut_in_q, dut_in_d;
   logic                err_q, err_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   logic                 w_in_xfer, w_in_last, w_in_final, w_abort;
   logic                 w_capture, w_out_xfer, w_out_last, w_out_final;
   logic [IN_PAD_W-1:0]  w_in_shifted;
   logic [CHUNK_W-1:0]   w_in_top;
   logic [OUT_PAD_W-1:0] w_out_shifted;
   logic [CHUNK_W-1:0]   w_out_top;
   logic [OUT_PAD_W-1:0] w_out_ext;
   logic                 w_unused;

   assign w_in_xfer   = s_valid && (state_q == LOAD);
   assign w_in_final  = w_in_xfer && w_in_last;
   // An early s_last throws away the partial frame; the count restarts.
   assign w_abort     = w_in_xfer && s_last && !w_in_last;
   assign w_capture   = (state_q == SETTLE) && (settle_q == '0);
   assign w_out_xfer  = (state_q == SEND) && m_ready;
   assign w_out_final = w_out_xfer && w_out_last;
   assign w_out_ext   = OUT_PAD_W'(dut_out);

   // Pad bits above IN_W and the non-shifting views of the shifters are
   // intentionally unused.
   assign w_unused = ^{w_in_shifted, w_in_top, w_out_shifted};

   flat_chunk_shifter #(
      .CHUNK_W  (CHUNK_W),
      .N_CHUNKS (IN_CHUNKS)
   ) u_in_shifter (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (1'b0),
      .load_data_i  ('0),
      .shift_i      (w_in_xfer),
      .shift_data_i (s_data),
      .clr_i        (w_abort),
      .shifted_o    (w_in_shifted),
      .top_chunk_o  (w_in_top),
      .last_o       (w_in_last)
   );

   flat_chunk_shifter #(
      .CHUNK_W  (CHUNK_W),
      .N_CHUNKS (OUT_CHUNKS)
   ) u_out_shifter (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (w_capture),
      .load_data_i  (w_out_ext),
      .shift_i      (w_out_xfer),
      .shift_data_i ('0),
      .clr_i        (1'b0),
      .shifted_o    (w_out_shifted),
      .top_chunk_o  (w_out_top),
      .last_o       (w_out_last)
   );

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         settle_q    <= '0;
         dut_in_q    <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         dut_in_q    <= dut_in_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Next-state and datapath next values.
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      dut_in_d    = dut_in_q;
      err_d       = err_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         LOAD: begin
            if (w_in_final) begin
               // Includes the chunk arriving on this edge.
               dut_in_d = w_in_shifted[IN_W-1:0];
               settle_d = SET_W'(DUT_LAT);
               state_d  = SETTLE;
               if (!s_last) begin
                  err_d = 1'b1;
               end
            end else if (w_abort) begin
               err_d = 1'b1;
            end
         end
         SETTLE: begin
            if (settle_q == '0) begin
               state_d = SEND;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         SEND: begin
            if (w_out_final) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      s_ready = (state_q == LOAD);
      m_valid = (state_q == SEND);
      m_data  = (state_q == SEND) ? w_out_top : '0;
      m_last  = (state_q == SEND) && w_out_last;
   end

   assign dut_in    = dut_in_q;
   assign err       = err_q;
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
